// File: rtl/nav_pkg.sv
// Shared types and default constants for the navigation sequencer.
package nav_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      TURN   = 3'd1,
      MOVE   = 3'd2,
      DECEL  = 3'd3,
      EDECEL = 3'd4
   } nav_state_t;

   localparam logic [10:0] DEF_SPD_INC = 11'h018;
   localparam logic [10:0] DEF_MIN_SPD = 11'h060;
   localparam logic [10:0] DEF_MAX_SPD = 11'h2A0;

   localparam int DECEL_MULT  = 2;
   localparam int EDECEL_MULT = 4;

   function automatic logic [10:0] sat_sub(input logic [10:0] a, input logic [10:0] b);
      return (a > b) ? (a - b) : 11'd0;
   endfunction

endpackage

// File: rtl/opn_edge_det.sv
// Rising-edge detector for the three IR opening sensors; history resets to
// "open" so an opening present at reset or command time is not an edge.
module opn_edge_det (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opn,
   output logic [2:0] rise
);

   logic [2:0] prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev <= 3'b111;
      else     prev <= opn;
   end

   assign rise = opn & ~prev;

endmodule

// File: rtl/nav_ctrl.sv
// Navigation sequencer: turns and forward moves with speed ramps paced by
// gyro ticks, completing on heading capture or opening/obstacle detection.
module nav_ctrl
   import nav_pkg::*;
#(
   parameter logic [10:0] SPD_INC = DEF_SPD_INC,
   parameter logic [10:0] MIN_SPD = DEF_MIN_SPD,
   parameter logic [10:0] MAX_SPD = DEF_MAX_SPD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_vld,
   input  logic        cmd_turn,
   input  logic [11:0] cmd_hdng,
   input  logic        cmd_stop_lft,
   input  logic        cmd_stop_rght,
   output logic        cmd_rdy,
   input  logic        at_hdng,
   input  logic        hdng_vld,
   input  logic        lft_opn,
   input  logic        rght_opn,
   input  logic        frwrd_opn,
   output logic        moving,
   output logic [11:0] dsrd_hdng,
   output logic [10:0] frwrd_spd,
   output logic        mv_cmplt
);

   localparam logic [10:0] DECEL_STEP  = 11'(SPD_INC * DECEL_MULT);
   localparam logic [10:0] EDECEL_STEP = 11'(SPD_INC * EDECEL_MULT);

   nav_state_t  state, nxt_state;
   logic [10:0] spd_nxt;
   logic [11:0] hdng_nxt;
   logic        cmplt_nxt;
   logic        stop_lft_q, stop_rght_q, stop_lft_nxt, stop_rght_nxt;
   logic [2:0]  opn_rise;
   logic        unused_frwrd_rise;
   logic        stop_hit;
   logic [11:0] accel_sum;
   logic [10:0] accel_spd;

   opn_edge_det u_edge (
      .clk  (clk),
      .rst  (rst),
      .opn  ({frwrd_opn, rght_opn, lft_opn}),
      .rise (opn_rise)
   );

   assign unused_frwrd_rise = opn_rise[2];
   assign stop_hit = (stop_lft_q & opn_rise[0]) | (stop_rght_q & opn_rise[1]);

   // Sum one bit wider than the speed so the clamp sees true overflow.
   assign accel_sum = {1'b0, frwrd_spd} + {1'b0, SPD_INC};
   assign accel_spd = (accel_sum > {1'b0, MAX_SPD}) ? MAX_SPD : accel_sum[10:0];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt_state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frwrd_spd   <= '0;
         dsrd_hdng   <= '0;
         mv_cmplt    <= 1'b0;
         stop_lft_q  <= 1'b0;
         stop_rght_q <= 1'b0;
      end else begin
         frwrd_spd   <= spd_nxt;
         dsrd_hdng   <= hdng_nxt;
         mv_cmplt    <= cmplt_nxt;
         stop_lft_q  <= stop_lft_nxt;
         stop_rght_q <= stop_rght_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first, so no path
      // through the case can infer a latch.
      nxt_state     = state;
      spd_nxt       = frwrd_spd;
      hdng_nxt      = dsrd_hdng;
      cmplt_nxt     = 1'b0;
      stop_lft_nxt  = stop_lft_q;
      stop_rght_nxt = stop_rght_q;
      case (state)
         IDLE: begin
            if (cmd_vld) begin
               if (cmd_turn) begin
                  hdng_nxt  = cmd_hdng;
                  nxt_state = TURN;
               end else if (frwrd_opn) begin
                  stop_lft_nxt  = cmd_stop_lft;
                  stop_rght_nxt = cmd_stop_rght;
                  spd_nxt       = MIN_SPD;
                  nxt_state     = MOVE;
               end else begin
                  cmplt_nxt = 1'b1;
               end
            end
         end
         TURN: begin
            if (at_hdng && hdng_vld) begin
               nxt_state = IDLE;
               cmplt_nxt = 1'b1;
            end
         end
         MOVE: begin
            // A stop wins over a same-cycle tick: speed holds that cycle.
            if (!frwrd_opn)    nxt_state = EDECEL;
            else if (stop_hit) nxt_state = DECEL;
            else if (hdng_vld) spd_nxt   = accel_spd;
         end
         DECEL: begin
            if (!frwrd_opn) begin
               nxt_state = EDECEL;
            end else if (hdng_vld) begin
               spd_nxt = sat_sub(frwrd_spd, DECEL_STEP);
               if (spd_nxt == '0) begin
                  nxt_state = IDLE;
                  cmplt_nxt = 1'b1;
               end
            end
         end
         EDECEL: begin
            if (hdng_vld) begin
               spd_nxt = sat_sub(frwrd_spd, EDECEL_STEP);
               if (spd_nxt == '0) begin
                  nxt_state = IDLE;
                  cmplt_nxt = 1'b1;
               end
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_comb begin
      cmd_rdy = (state == IDLE);
      moving  = (state == TURN) || (state == MOVE) || (state == DECEL) || (state == EDECEL);
   end

endmodule

// File: tb/tb_nav_ctrl.sv
// Scoreboarded bench for nav_ctrl: expected speeds queued per gyro tick and
// compared after the tick edge; completion and handshake checked directly.
module tb_nav_ctrl;

   logic        clk, rst;
   logic        cmd_vld, cmd_turn, cmd_stop_lft, cmd_stop_rght;
   logic [11:0] cmd_hdng;
   logic        cmd_rdy, at_hdng, hdng_vld;
   logic        lft_opn, rght_opn, frwrd_opn;
   logic        moving, mv_cmplt;
   logic [11:0] dsrd_hdng;
   logic [10:0] frwrd_spd;

   int n_checks = 0;
   int n_pass   = 0;
   int m_spd    = 0;
   int cmplt_cnt = 0;
   int c0;
   int sb[$];

   nav_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_vld       (cmd_vld),
      .cmd_turn      (cmd_turn),
      .cmd_hdng      (cmd_hdng),
      .cmd_stop_lft  (cmd_stop_lft),
      .cmd_stop_rght (cmd_stop_rght),
      .cmd_rdy       (cmd_rdy),
      .at_hdng       (at_hdng),
      .hdng_vld      (hdng_vld),
      .lft_opn       (lft_opn),
      .rght_opn      (rght_opn),
      .frwrd_opn     (frwrd_opn),
      .moving        (moving),
      .dsrd_hdng     (dsrd_hdng),
      .frwrd_spd     (frwrd_spd),
      .mv_cmplt      (mv_cmplt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Drives one gyro tick and queues the speed the model expects after it.
   // mode: 0 hold, 1 accelerate, 2 decel, 3 emergency decel.
   task automatic tick(input int mode);
      @(negedge clk);
      case (mode)
         1: begin m_spd += 24; if (m_spd > 672) m_spd = 672; end
         2: begin m_spd -= 48; if (m_spd < 0) m_spd = 0; end
         3: begin m_spd -= 96; if (m_spd < 0) m_spd = 0; end
         default: ;
      endcase
      sb.push_back(m_spd);
      hdng_vld = 1'b1;
      @(negedge clk);
      hdng_vld = 1'b0;
   endtask

   task automatic issue_move(input logic sl, input logic sr);
      @(negedge clk);
      cmd_vld = 1'b1; cmd_turn = 1'b0; cmd_stop_lft = sl; cmd_stop_rght = sr;
      @(negedge clk);
      cmd_vld = 1'b0;
      if (frwrd_opn) begin
         m_spd = 96;
         check("move_rdy", cmd_rdy, 0);
         check("move_moving", moving, 1);
         check("move_min_spd", frwrd_spd, 11'h060);
      end
   endtask

   task automatic expect_done(input string tag);
      check({tag, "_cmplt"}, mv_cmplt, 1);
      check({tag, "_rdy"}, cmd_rdy, 1);
      check({tag, "_spd0"}, frwrd_spd, 0);
      @(negedge clk);
      check({tag, "_cmplt_drop"}, mv_cmplt, 0);
      check({tag, "_idle"}, moving, 0);
   endtask

   // Monitor: after every edge that saw a tick, pop and compare the speed.
   initial begin
      logic t;
      forever begin
         @(posedge clk);
         t = hdng_vld && !rst;
         #2;
         if (t) begin
            if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
            else check("tick_spd", frwrd_spd, sb.pop_front());
         end
         if (!rst && mv_cmplt) cmplt_cnt++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      cmd_vld = 0; cmd_turn = 0; cmd_hdng = '0; cmd_stop_lft = 0; cmd_stop_rght = 0;
      at_hdng = 0; hdng_vld = 0; lft_opn = 0; rght_opn = 0; frwrd_opn = 1;
      repeat (2) @(negedge clk);
      check("rst_rdy", cmd_rdy, 1);
      check("rst_moving", moving, 0);
      check("rst_spd", frwrd_spd, 0);
      check("rst_hdng", dsrd_hdng, 0);
      check("rst_cmplt", mv_cmplt, 0);
      rst = 1'b0;
      @(negedge clk);

      // Reset in the middle of a move at 0x1B0.
      issue_move(0, 0);
      repeat (14) tick(1);
      check("pre_rst_spd", frwrd_spd, 11'h1B0);
      c0 = cmplt_cnt;
      #1 rst = 1'b1;
      #1;
      check("async_rst_spd", frwrd_spd, 0);
      check("async_rst_moving", moving, 0);
      check("async_rst_rdy", cmd_rdy, 1);
      m_spd = 0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_no_cmplt", cmplt_cnt, c0);

      // Turn: at_hdng without a tick holds; stray command ignored.
      @(negedge clk);
      cmd_vld = 1; cmd_turn = 1; cmd_hdng = 12'h3FF;
      @(negedge clk);
      cmd_vld = 0;
      check("turn_rdy", cmd_rdy, 0);
      check("turn_moving", moving, 1);
      check("turn_hdng", dsrd_hdng, 12'h3FF);
      at_hdng = 1;
      c0 = cmplt_cnt;
      repeat (10) @(negedge clk);
      cmd_vld = 1; cmd_turn = 1; cmd_hdng = 12'h123;
      @(negedge clk);
      cmd_vld = 0; cmd_turn = 0;
      repeat (9) @(negedge clk);
      check("turn_hold_moving", moving, 1);
      check("turn_ignore_hdng", dsrd_hdng, 12'h3FF);
      check("turn_no_cmplt", cmplt_cnt, c0);
      tick(0);
      expect_done("turn");
      check("turn_one_pulse", cmplt_cnt, c0 + 1);
      at_hdng = 0;

      // Free move: accelerate 30 ticks, saturating at 0x2A0 on tick 24.
      issue_move(0, 0);
      repeat (23) tick(1);
      check("accel_23", frwrd_spd, 11'h288);
      repeat (7) tick(1);
      check("accel_hold", frwrd_spd, 11'h2A0);
      @(negedge clk);
      frwrd_opn = 0;
      @(negedge clk);
      check("edecel_entry_moving", moving, 1);
      repeat (7) tick(3);
      expect_done("edecel1");
      frwrd_opn = 1;

      // Left-stop move: rising lft_opn together with a tick goes to DECEL.
      issue_move(1, 0);
      repeat (24) tick(1);
      @(negedge clk);
      lft_opn = 1;
      sb.push_back(m_spd);
      hdng_vld = 1;
      @(negedge clk);
      hdng_vld = 0;
      check("decel_entry_moving", moving, 1);
      repeat (13) tick(2);
      check("decel_13_moving", moving, 1);
      tick(2);
      expect_done("decel");

      // Opening already present at command time does not stop the move.
      issue_move(1, 0);
      repeat (24) tick(1);
      check("held_opn_moving", moving, 1);
      @(negedge clk);
      frwrd_opn = 0;
      @(negedge clk);
      check("edecel2_hold_spd", frwrd_spd, 11'h2A0);
      repeat (7) tick(3);
      expect_done("edecel2");

      // Move command with a blocked path completes immediately.
      c0 = cmplt_cnt;
      issue_move(0, 0);
      check("nomove_rdy", cmd_rdy, 1);
      check("nomove_moving", moving, 0);
      check("nomove_cmplt", mv_cmplt, 1);
      check("nomove_spd", frwrd_spd, 0);
      @(negedge clk);
      check("nomove_cmplt_drop", mv_cmplt, 0);
      check("nomove_one_pulse", cmplt_cnt, c0 + 1);

      check("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/nav_ctrl.md
# nav_ctrl

Navigation sequencer that sits between the maze command source and the heading PID. It accepts one command at a time, either "turn to heading" or "move forward until an opening or obstacle". From that command it drives the PID's `dsrd_hdng`, `moving` and `frwrd_spd` inputs, ramping forward speed up and down on gyro ticks. It uses the PID's `at_hdng` and the IR opening sensors to decide when a command is complete.

## Interface
- `SPD_INC`, 11'h018: forward-speed step per `hdng_vld` while accelerating.
- `MIN_SPD`, 11'h060: forward speed loaded when a move starts.
- `MAX_SPD`, 11'h2A0: forward-speed ceiling.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_vld`  in  1  command strobe; sampled only in IDLE.
- `cmd_turn`  in  1  1 = turn to `cmd_hdng`; 0 = forward move.
- `cmd_hdng`  in  12  signed target heading for a turn.
- `cmd_stop_lft`, `cmd_stop_rght`  in  1  move stops at a new left / right opening.
- `cmd_rdy`  out  1  high exactly while in IDLE.
- `at_hdng`  in  1  heading error is small (from the PID).
- `hdng_vld`  in  1  one-cycle gyro tick; paces ramps and turn completion.
- `lft_opn`, `rght_opn`, `frwrd_opn`  in  1  IR sensors; 1 = open.
- `moving`  out  12→1  high in TURN, MOVE, DECEL and EDECEL.
- `dsrd_hdng`  out  12  registered desired heading.
- `frwrd_spd`  out  11  registered unsigned forward speed.
- `mv_cmplt`  out  1  one-cycle pulse on command completion.

## Operation
- States: IDLE, TURN, MOVE, DECEL, EDECEL.
- IDLE
  - `frwrd_spd` = 0.
  - `cmd_vld` with `cmd_turn` = 1: `dsrd_hdng` <= `cmd_hdng`, go to TURN.
  - `cmd_vld` with `cmd_turn` = 0 and `frwrd_opn` = 1: latch both stop flags, `frwrd_spd` <= `MIN_SPD`, go to MOVE.
  - `cmd_vld` with `cmd_turn` = 0 and `frwrd_opn` = 0: stay in IDLE, speed stays 0, pulse `mv_cmplt`.
- TURN
  - `frwrd_spd` = 0.
  - Exit to IDLE when `at_hdng` and `hdng_vld` are high in the same cycle.
- MOVE
  - On each `hdng_vld`: `frwrd_spd` <= min(`frwrd_spd` + `SPD_INC`, `MAX_SPD`).
  - The sum is computed 12 bits wide, so it never wraps.
- Stop conditions in MOVE, evaluated every cycle:
  - `frwrd_opn` = 0 → EDECEL.
  - Otherwise, a latched left flag with a rising edge on `lft_opn`, or a latched right flag with a rising edge on `rght_opn` → DECEL.
- Rising edge = current 1, previous-cycle 0.
  - The previous-value registers update every cycle in all states and reset to 1.
  - An opening already present at command time therefore never triggers a stop.
- DECEL
  - On each `hdng_vld`: subtract 2×`SPD_INC`, saturating at 0.
  - `frwrd_opn` = 0 in DECEL → EDECEL.
- EDECEL
  - On each `hdng_vld`: subtract 4×`SPD_INC`, saturating at 0.
- DECEL and EDECEL go to IDLE on the edge where `frwrd_spd` becomes 0.
- A stop condition and `hdng_vld` in the same MOVE cycle: the stop wins, with no increment and no decrement that cycle.
- `cmd_vld` outside IDLE is ignored.

## Timing
- Reset values:
  - State IDLE, `cmd_rdy` = 1, `moving` = 0, `frwrd_spd` = 0, `dsrd_hdng` = 0, `mv_cmplt` = 0.
  - Previous-opening registers = 1.
- Reset asserted mid-command forces all of the above immediately (asynchronous).
- Command accepted on the edge where `cmd_vld` and `cmd_rdy` are both high.
  - `cmd_rdy` drops and `moving` rises in the next cycle.
  - `dsrd_hdng` or `frwrd_spd` = `MIN_SPD` is valid in that same cycle.
- `moving` and `cmd_rdy` are decoded from the state register, so they are glitch-free.
- `mv_cmplt` is registered and high for exactly the first IDLE cycle after TURN, DECEL or EDECEL.
  - In the no-move case, it is high in the cycle after the `cmd_vld` acceptance edge.
- With default parameters:
  - Acceleration from `MIN_SPD` to `MAX_SPD` takes 24 ticks.
  - DECEL from `MAX_SPD` takes 14 ticks.
  - EDECEL from `MAX_SPD` takes 7 ticks.

## Structure
- Package `nav_pkg`:
  - State enum `nav_state_t`.
  - Default `SPD_INC`, `MIN_SPD`, `MAX_SPD` constants.
  - Decel multipliers 2 and 4.
- Sub-module `opn_edge_det`: three-bit registered rising-edge detector for the opening sensors, instantiated once.
- The state machine and speed datapath stay in `nav_ctrl`.

## Test plan
- Reset mid-MOVE at `frwrd_spd` = 0x1B0 → same cycle: `frwrd_spd` = 0, `moving` = 0, `cmd_rdy` = 1; no `mv_cmplt` pulse.
- Turn to `cmd_hdng` = 0x3FF with `at_hdng` high and no tick for 20 cycles → stays in TURN; next `hdng_vld` → one `mv_cmplt` pulse, then IDLE.
- Move, both stop flags 0, 30 ticks → speed 0x060, 0x078, … reaches 0x2A0 on tick 24 and holds at 0x2A0.
- Move at 0x2A0 with `cmd_stop_lft` = 1; `lft_opn` 0→1 → DECEL; 14 ticks later speed = 0 and `mv_cmplt` pulses.
- Move with `lft_opn` = 1 from command time and stop-left set → no stop; `frwrd_opn` → 0 at 0x2A0 → EDECEL, zero after 7 ticks.
- Move command with `frwrd_opn` = 0 → stays in IDLE, `mv_cmplt` pulses, `moving` never rises; `cmd_vld` during TURN is ignored.
